// File: rtl/drv_clkctl_if.sv
// drv_clkctl_if -- control/configuration bus of the divided-clock sequencer.
//   cfg_wr/cfg_div/cfg_ack : divisor update request/acknowledge
//   start/stop             : level-sampled run control
//   burst_n                : pulse count, present only with CLKCTL_BURST_EN
//   clko/tick/busy/done    : generated clock and status
// Modports: master (control logic side), slave (drv_clkctl side).
interface drv_clkctl_if #(
  parameter int unsigned DIVW = 16,
  parameter int unsigned CNTW = 8
);
  logic            cfg_wr;
  logic [DIVW-1:0] cfg_div;
  logic            cfg_ack;
  logic            start;
  logic            stop;
`ifdef CLKCTL_BURST_EN
  logic [CNTW-1:0] burst_n;
`endif
  logic            clko;
  logic            tick;
  logic            busy;
  logic            done;

`ifdef CLKCTL_BURST_EN
  modport master (
    output cfg_wr, cfg_div, start, stop, burst_n,
    input  cfg_ack, clko, tick, busy, done
  );
  modport slave (
    input  cfg_wr, cfg_div, start, stop, burst_n,
    output cfg_ack, clko, tick, busy, done
  );
`else
  modport master (
    output cfg_wr, cfg_div, start, stop,
    input  cfg_ack, clko, tick, busy, done
  );
  modport slave (
    input  cfg_wr, cfg_div, start, stop,
    output cfg_ack, clko, tick, busy, done
  );
`endif
endinterface

// File: rtl/drv_clkctl.sv
// drv_clkctl -- run-control and reconfiguration sequencer for a divided clock.
// clko has a half-period of div_act clk cycles. New divisors are taken through
// a cfg_wr/cfg_ack handshake and applied in IDLE or on a clko falling edge.
// Start/stop never produce a runt pulse on clko.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : drv_clkctl_if.slave (cfg_wr, cfg_div, cfg_ack, start, stop,
//          [burst_n], clko, tick, busy, done)
// Optional feature: define CLKCTL_BURST_EN to add burst_n and a pulse counter
// that stops the clock after burst_n rising edges (0 = continuous).
module drv_clkctl #(
  parameter int unsigned SYSFREQ = 50000000,
  parameter int unsigned DIVW    = 16,
  parameter int unsigned CNTW    = 8,
  parameter int unsigned DEFDIV  = SYSFREQ / 2000000
) (
  input  logic         clk,
  input  logic         rst,
  drv_clkctl_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;

  localparam logic [DIVW-1:0] DIV_RST = DIVW'(DEFDIV);

  state_t          state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] div_act_q, div_act_d;
  logic [DIVW-1:0] div_pend_q, div_pend_d;
  logic            pend_q, pend_d;
  logic            apl_q, apl_d;
  logic            ack_q, ack_d;
  logic            clko_q, clko_d;
  logic            tick_q, tick_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            at_edge;
`ifdef CLKCTL_BURST_EN
  logic [CNTW-1:0] burst_q, burst_d;
  logic [CNTW-1:0] pulses_q, pulses_d;
`endif

  assign at_edge = (cnt_q >= div_act_q - DIVW'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clko_d     = clko_q;
    tick_d     = 1'b0;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    apl_d      = 1'b0;
    ack_d      = apl_q;
`ifdef CLKCTL_BURST_EN
    burst_d    = burst_q;
    pulses_d   = pulses_q;
`endif

    // apl_q covers the gap between apply and ack so a still-held cfg_wr is not re-captured
    if (bus.cfg_wr && !pend_q && !apl_q && !ack_q) begin
      pend_d     = 1'b1;
      div_pend_d = (bus.cfg_div == '0) ? DIVW'(1) : bus.cfg_div;
    end

    case (state_q)
      ST_IDLE: begin
        clko_d = 1'b0;
        cnt_d  = '0;
        if (pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
          apl_d     = 1'b1;
        end
        if (bus.start && !bus.stop) begin
          state_d = ST_RUN;
`ifdef CLKCTL_BURST_EN
          burst_d  = bus.burst_n;
          pulses_d = '0;
`endif
        end
      end
      default: begin
        if (!at_edge) begin
          cnt_d = cnt_q + DIVW'(1);
        end else begin
          cnt_d = '0;
          if (clko_q) begin
            // falling edge: full-period boundary, safe point for a divisor swap
            clko_d = 1'b0;
            if (pend_q) begin
              div_act_d = div_pend_q;
              pend_d    = 1'b0;
              apl_d     = 1'b1;
            end
          end else if (state_q == ST_RUN) begin
            clko_d = 1'b1;
            tick_d = 1'b1;
`ifdef CLKCTL_BURST_EN
            pulses_d = pulses_q + CNTW'(1);
            if (burst_q != '0 && pulses_q + CNTW'(1) == burst_q) begin
              state_d = ST_STOP;
            end
`endif
          end
          if (state_q == ST_STOP) begin
            state_d = ST_IDLE;
          end
        end
        if (state_q == ST_RUN && bus.stop) begin
          state_d = ST_STOP;
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_act_q  <= DIV_RST;
      div_pend_q <= DIV_RST;
      pend_q     <= 1'b0;
      apl_q      <= 1'b0;
      ack_q      <= 1'b0;
      clko_q     <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CLKCTL_BURST_EN
      burst_q    <= '0;
      pulses_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      apl_q      <= apl_d;
      ack_q      <= ack_d;
      clko_q     <= clko_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CLKCTL_BURST_EN
      burst_q    <= burst_d;
      pulses_q   <= pulses_d;
`endif
    end
  end

  assign bus.cfg_ack = ack_q;
  assign bus.clko    = clko_q;
  assign bus.tick    = tick_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_drv_clkctl.sv
// tb_drv_clkctl -- randomized episodes against a timeline model of drv_clkctl.
// Each episode is planned up front (start edge, divisor swap edge, end edge);
// expected outputs for every cycle follow from those edges by plain arithmetic.
module tb_drv_clkctl;
  localparam int unsigned DIVW   = 16;
  localparam int unsigned CNTW   = 8;
  localparam int unsigned DEFDIV = 25;
  localparam int          BIG    = 1 << 30;

  logic clk = 1'b0;
  logic rst;

  drv_clkctl_if #(.DIVW(DIVW), .CNTW(CNTW)) bus ();

  drv_clkctl #(
    .SYSFREQ(50000000),
    .DIVW   (DIVW),
    .CNTW   (CNTW),
    .DEFDIV (DEFDIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  // timeline plan: k = start edge, a_t = divisor swap edge, e_t = return to IDLE
  int k       = BIG;
  int a_t     = BIG;
  int e_t     = 0;
  int done_t  = BIG;
  int ack1    = BIG;
  int ack2    = BIG;
  int d1      = 1;
  int d2      = 1;
  int cur_div = DEFDIV;

  function automatic logic exp_clko(input int t);
    if (t < k || t >= e_t) return 1'b0;
    if (t < a_t) return (((t - k) / d1) % 2) == 1;
    return (((t - a_t) / d2) % 2) == 1;
  endfunction

  function automatic logic exp_tick(input int t);
    if (t < k || t >= e_t) return 1'b0;
    if (t < a_t) return ((t - k) % (2 * d1)) == d1;
    return ((t - a_t) % (2 * d2)) == d2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    check_eq("clko",    32'(bus.clko),    32'(exp_clko(cyc)));
    check_eq("tick",    32'(bus.tick),    32'(exp_tick(cyc)));
    check_eq("busy",    32'(bus.busy),    32'(cyc >= k && cyc < e_t));
    check_eq("done",    32'(bus.done),    32'(cyc == done_t));
    check_eq("cfg_ack", 32'(bus.cfg_ack), 32'(cyc == ack1 || cyc == ack2));
  endtask

  // idle_div/run_div < 0: no update; c_off/stop_off 0: random;
  // stop_mode 0: stop at offset, 1: stop lands on the swap edge, 2: burst end
  task automatic episode(input int idle_div, input bit both, input int run_div,
                         input int c_off, input int stop_mode, input int stop_off,
                         input int burst);
    int  c, s, lo, t;
    bit  run_cfg;
    run_cfg = (run_div >= 0);
    if (idle_div >= 0) begin
      bus.cfg_div = DIVW'(idle_div);
      bus.cfg_wr  = 1'b1;
      ack1        = cyc + 3;
      cur_div     = (idle_div == 0) ? 1 : idle_div;
      repeat (3) step();
      bus.cfg_wr = 1'b0;
      step();
    end
    if (both) begin
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step();
      bus.stop  = 1'b0;
    end
    d1     = cur_div;
    k      = cyc + 1;
    a_t    = BIG;
    e_t    = BIG;
    done_t = BIG;
`ifdef CLKCTL_BURST_EN
    bus.burst_n = CNTW'(burst);
`endif
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;

    c = BIG;
    if (run_cfg) begin
      c           = k + ((c_off > 0) ? c_off : int'($urandom_range(1, 3 * d1)));
      d2          = (run_div == 0) ? 1 : run_div;
      a_t         = k + 2 * d1 * ((c - k) / (2 * d1) + 1);
      ack2        = a_t + 1;
      bus.cfg_div = DIVW'(run_div);
    end

    s = BIG;
    if (stop_mode == 2) begin
      e_t = k + 2 * d1 * burst;
    end else begin
      if (stop_mode == 1 && run_cfg) begin
        lo = (c + 1 > a_t - d1) ? c + 1 : a_t - d1;
        if (lo <= a_t - 1) s = lo + int'($urandom_range(0, a_t - 1 - lo));
      end
      if (s == BIG) begin
        s = (run_cfg ? a_t + 1 : k) +
            ((stop_off > 0) ? stop_off : int'($urandom_range(1, 4 * (run_cfg ? d2 : d1))));
      end
      e_t = (s < a_t) ? k + d1 * ((s - k) / d1 + 1) : a_t + d2 * ((s - a_t) / d2 + 1);
    end
    done_t = e_t;

    while (cyc < e_t + 3) begin
      t          = cyc + 1;
      bus.cfg_wr = run_cfg && t >= c && t <= ack2;
      bus.stop   = (t == s) || (t > e_t && $urandom_range(0, 1) == 1);
      bus.start  = (t > k && t <= e_t) ? ($urandom_range(0, 1) == 1) : 1'b0;
      step();
    end
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.cfg_wr = 1'b0;
    if (run_cfg) cur_div = d2;
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    bus.cfg_wr  = 1'b0;
    bus.cfg_div = '0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
`ifdef CLKCTL_BURST_EN
    bus.burst_n = '0;
`endif
    repeat (2) step();
    rst = 1'b0;
    step();

    // directed: default divisor, mid-high-phase update, stop at cnt=3, div 0, coincident stop
    episode(-1, 1'b0, -1, 0, 0, 60, 0);
    episode(10, 1'b0, 4, 12, 0, 5, 0);
    episode(10, 1'b0, -1, 0, 0, 14, 0);
    episode(0, 1'b1, -1, 0, 0, 7, 0);
    episode(10, 1'b0, 3, 5, 1, 0, 0);
`ifdef CLKCTL_BURST_EN
    episode(2, 1'b1, -1, 0, 2, 0, 3);
    episode(3, 1'b0, -1, 0, 2, 0, 1);
`endif

    for (int i = 0; i < 25; i++) begin
      episode(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : -1,
              $urandom_range(0, 1) == 1,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : -1,
              0, int'($urandom_range(0, 1)), 0, 0);
    end

    // reset mid-run with an update pending
    episode(6, 1'b0, -1, 0, 0, 5, 0);
    d1     = cur_div;
    k      = cyc + 1;
    a_t    = BIG;
    e_t    = BIG;
    done_t = BIG;
    ack2   = BIG;
`ifdef CLKCTL_BURST_EN
    bus.burst_n = '0;
`endif
    bus.start = 1'b1;
    step();
    bus.start   = 1'b0;
    bus.cfg_div = DIVW'(3);
    bus.cfg_wr  = 1'b1;
    step();
    bus.cfg_wr = 1'b0;
    rst        = 1'b1;
    e_t        = cyc + 1;
    step();
    rst = 1'b0;
    repeat (20) step();
    cur_div = DEFDIV;
    episode(-1, 1'b0, -1, 0, 0, 60, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/drv_clkctl.md
# drv_clkctl

Run-control and reconfiguration sequencer for a programmable divided-clock generator. It derives `clko` from the system clock using a half-period divisor that can be rewritten at runtime. New divisors are accepted through a request/acknowledge handshake and applied only on period boundaries. Start and stop are glitch-free, so `clko` never produces a runt pulse. It sits between control logic (FSMs, register files) and peripherals clocked or strobed by `clko`/`tick`.

## Interface
- `SYSFREQ`, 50000000: system clock frequency in Hz. Informative only; used to derive `DEFDIV` at instantiation.
- `DIVW`, 16: width of the half-period divisor.
- `CNTW`, 8: width of the burst counter (burst feature only).
- `DEFDIV`, 25: active divisor after reset (1 MHz output at 50 MHz).

Ports:
- `clk`  in  1  system clock. One clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_wr`  in  1  divisor write request. Held high until `cfg_ack`.
- `cfg_div`  in  DIVW  requested half-period in `clk` cycles. Stable while `cfg_wr` is high.
- `cfg_ack`  out  1  one-cycle acknowledge. High in the cycle after the new divisor becomes active.
- `start`  in  1  begin clock generation. Level-sampled.
- `stop`  in  1  end clock generation. Level-sampled.
- `burst_n`  in  CNTW  pulse count, sampled on an accepted `start`. Present only with `CLKCTL_BURST_EN`.
- `clko`  out  1  generated clock, registered.
- `tick`  out  1  one-cycle pulse, high in the first cycle `clko` is high.
- `busy`  out  1  high in RUN and STOP.
- `done`  out  1  one-cycle pulse on return to IDLE from RUN or STOP.

## Operation
- State machine with three states: IDLE, RUN, STOP.
- IDLE:
  - `clko`=0, counter `cnt`=0.
  - `start` (without `stop`) → RUN, with `cnt` ← 0.
  - `stop` alone is ignored.
  - `start` and `stop` in the same cycle → remain IDLE.
- RUN:
  - If `cnt` < `div_act`−1, `cnt` increments.
  - Otherwise `cnt` ← 0 and `clko` toggles; on the low→high toggle, `tick` is also set.
  - `start` is ignored.
  - `stop` → STOP.
- STOP:
  - Counting continues.
  - At the next toggle point, if `clko` is high it falls; if `clko` is low it stays low.
  - In either case the state → IDLE and `done` pulses.
- Divisor arithmetic:
  - `cfg_div`=0 is stored as 1.
  - Output period = 2·`div_act` cycles; duty cycle 50 %.
  - `cnt` is DIVW bits wide and never exceeds `div_act`−1.
- Configuration handshake:
  - While no update is pending and `cfg_ack` is low, `cfg_wr`=1 captures `cfg_div` into `div_pend`.
  - In IDLE, `div_act` ← `div_pend` at the next edge.
  - In RUN/STOP, the update is applied at the edge where `clko` falls (full-period boundary), with `cnt` ← 0.
  - `cfg_ack` is high in the cycle after the update is applied.
  - `cfg_wr` seen while an update is pending or `cfg_ack` is high is ignored. The master must drop `cfg_wr` on `cfg_ack`.
- `rst` mid-operation:
  - All state returns to reset values on that edge.
  - A pending update is discarded and no `cfg_ack` is issued.
  - `div_act` ← `DEFDIV`.
- Reset values: `clko`=0, `tick`=0, `cfg_ack`=0, `busy`=0, `done`=0; state IDLE, `cnt`=0, `div_act`=`DEFDIV`, nothing pending.

## Timing
- `start` sampled at edge k → `clko` high after edge k+`div_act`. `tick` is high in that same cycle.
- Steady state: edges of `clko` every `div_act` cycles.
- `busy` is high from edge k until the edge that enters IDLE.
- Config in IDLE: `cfg_wr` sampled at edge j → `div_act` updated at edge j+1 → `cfg_ack` high after edge j+2 for one cycle.
- Config in RUN: at most 2·`div_act_old` cycles from capture to application, plus one cycle to `cfg_ack`.
- Stop latency: at most `div_act` cycles from `stop` to IDLE. `done` is high in the first IDLE cycle.
- Update and stop coinciding at the same falling edge: both take effect; `div_act` updated, then IDLE.

## Configuration
- Macro: `CLKCTL_BURST_EN`.
- Defined:
  - The `burst_n` port and a CNTW-bit pulse counter exist. `burst_n` is latched on the accepted `start`.
  - `burst_n` ≠ 0: after the `burst_n`-th rising edge of `clko`, the FSM enters STOP automatically; `clko` falls normally and `done` pulses.
  - `burst_n`=0: continuous operation.
  - An external `stop` still ends a burst early.
- Undefined: no `burst_n` port and no burst counter; operation is continuous until `stop`.

## Test plan
- Reset, then `start` at edge k with `DEFDIV`=25 → `clko` high at k+25, period 50 cycles, `tick` every 50 cycles, `busy`=1.
- RUN with div 10, `cfg_wr`/`cfg_div`=4 mid-high-phase → no change until the next falling edge, then `cfg_ack` for one cycle and period 8 cycles thereafter.
- RUN with div 10, `stop` when `clko` is high and `cnt`=3 → `clko` falls 6 cycles later, `done` pulses once, `busy`=0, no further edges.
- IDLE, `cfg_div`=0 → `cfg_ack` two edges after request; then `start` → `clko` toggles every cycle (period 2).
- With `CLKCTL_BURST_EN`, `burst_n`=3, div 2 → exactly 3 `tick` pulses; `done` the cycle after the third falling edge; `start`+`stop` in the same cycle in IDLE → stays IDLE, no `done`.
- `rst` during RUN with an update pending → next cycle all outputs 0, `cfg_ack` never asserts, restart shows `DEFDIV` period.
